// File: rtl/clkmeter.sv
// Period meter for a slow asynchronous clock or tick, measured in cycles of clk.
// Synchronizes clkin, detects rising edges and reports rise-to-rise distance with a one-cycle valid strobe.
module clkmeter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkin,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             s0;
  logic             s1;
  logic             prev;
  logic             rise;
  logic [WIDTH-1:0] counter;
  state_t           state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s0   <= clkin;
      s1   <= s0;
      prev <= s1;
    end
  end

  always_comb begin
    rise = s1 & ~prev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_LOW;
      counter <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        // Requiring a low level first keeps a high input at reset release from counting as an edge.
        WAIT_LOW: begin
          if (!s1) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (rise) begin
            counter <= CNT_ONE;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period  <= counter;
            valid   <= 1'b1;
            timeout <= 1'b0;
            counter <= CNT_ONE;
          end else if (counter == CNT_MAX) begin
            timeout <= 1'b1;
            state   <= WAIT_LOW;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        default: begin
          state <= WAIT_LOW;
        end
      endcase
    end
  end

endmodule
